aes_key_schedule_seq: RTL and testbench
=======================================

# aes_key_schedule_seq

Sequential AES-128 key schedule and round-key store for the decryption core. On a start request it latches the cipher key, generates round keys 1..10 at one per clock from four shared `aes_sbox` instances, and holds all 11 keys in an internal register file. The decryption round controller then reads keys by round index, typically 10 down to 0. This replaces per-round combinational re-expansion on the critical path.

## Interface
Parameters:
- `NR`, 10, number of rounds. Only 10 is supported.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_in`  in  128  cipher key. Word W0 = `key_in[127:96]`.
- `start`  in  1  request to expand `key_in`. Sampled on the clock edge.
- `busy`  out  1  expansion in progress.
- `keys_ready`  out  1  all 11 round keys are valid.
- `rd_round`  in  4  round index to read, 0..10.
- `rd_key`  out  128  registered round key for `rd_round`.
- `zeroize`  in  1  present only with `AES_KEY_ZEROIZE_EN`; clears the key store.

## Operation
- FSM states:
  - **IDLE**: reached from reset. `busy`=0, `keys_ready`=0.
  - **EXPAND**: `busy`=1, `keys_ready`=0.
  - **READY**: `busy`=0, `keys_ready`=1.
- Start handling:
  - `start` in IDLE or READY: `slot[0]` <= `key_in`, round counter `rc` <= 1, next state EXPAND, `keys_ready` drops on that same edge.
  - `start` in EXPAND: ignored. The current expansion completes unchanged.
- Each EXPAND cycle computes `slot[rc]` from `slot[rc-1]`:
  - temp = SubWord(RotWord(w3)) ^ Rcon(rc)
  - n0 = w0^temp; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2
  - RotWord rotates left by one byte.
  - Rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36, placed in byte 3 (bits 31:24).
- Counter `rc` is 4 bits. After writing `slot[10]`, the FSM goes to READY. `rc` never exceeds 10.
- Only four S-box lookups are used per cycle, on `slot[rc-1]` word 3.
- Read port:
  - `rd_key` <= `slot[rd_round]` when `keys_ready`=1 and `rd_round` <= 10.
  - Otherwise `rd_key` <= 0. This covers `rd_round` 11..15 and any read while not ready.
- Key material is never presented on `rd_key` while `keys_ready`=0.

## Timing
- Reset values: `busy`=0, `keys_ready`=0, `rd_key`=0, all slots=0, `rc`=0, state IDLE.
- Start latency:
  - `start` sampled at edge E0: `busy`=1 after E0.
  - `slot[k]` written at edge E0+k, k=1..10.
  - `keys_ready`=1 and `busy`=0 after E0+10. That is 10 cycles from start to ready.
- Read latency is 1 cycle: `rd_round` sampled at edge E gives `rd_key` valid after E. A new index may be presented every cycle.
- Reads issued in the same cycle that `keys_ready` first rises (the sampling edge is E0+10) return 0. The first valid read is sampled at E0+11.
- Restart from READY: `keys_ready` falls after the start edge. Any read sampled at that edge returns 0.
- `rst` asserted mid-expansion: at the next edge the block is in IDLE, all outputs are at reset values, and the slots are cleared. `rst` has priority over `start` and `zeroize`.

## Configuration
- `AES_KEY_ZEROIZE_EN` defined:
  - The `zeroize` port exists.
  - `zeroize`=1 at an edge clears all slots and `rd_key`, forces IDLE, and drops `busy`/`keys_ready`, all in that one cycle.
  - Priority is `rst` > `zeroize` > `start`.
- `AES_KEY_ZEROIZE_EN` undefined: no `zeroize` port. Slots are cleared only by `rst` and are overwritten by the next `start`.

## Test plan
- **FIPS-197 key**: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, pulse `start`.
  - `keys_ready` rises exactly 10 cycles later.
  - `rd_round`=1 gives a0fafe1788542cb123a339392a6c7605.
  - `rd_round`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `rd_round`=0 gives the input key.
- **Reverse sweep**: `rd_round` 10..0 on consecutive cycles → each key appears one cycle after its index, matching a software model. Indices 11 and 15 return 0.
- **Start while busy**: second `start` with a different key at cycle 4 of expansion → ignored. Keys match the first key and `keys_ready` timing is unchanged.
- **Reset mid-run**: `rst` at cycle 5 → `busy`=0, `keys_ready`=0, `rd_key`=0 next cycle. A subsequent `start` with key 000102030405060708090a0b0c0d0e0f yields round 10 key 13111d7fe3944a17f307a78b4d2b30c5.
- **Restart from READY**: new `start` → `keys_ready` low for 10 cycles, reads return 0, and the new keys are correct afterwards.
- **Zeroize** (`AES_KEY_ZEROIZE_EN` defined): `zeroize` pulse in READY → IDLE next cycle and all reads return 0. `zeroize` together with `start` → zeroize wins.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 key schedule: expands one round key per clock into an 11-entry store
// with a registered read port. Optional `AES_KEY_ZEROIZE_EN` adds a zeroize input.

module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Inverse as din^254 by square-and-multiply; 0 maps to 0 naturally.
  always_comb begin
    logic [7:0] s;
    s   = din;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s   = gmul(s, s);
      inv = gmul(inv, s);
    end
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_schedule_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic         busy,
  output logic         keys_ready,
  input  logic [3:0]   rd_round,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  output logic [127:0] rd_key
);
  localparam int LANES = 4;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t              state, state_nxt;
  logic [3:0]          rc;
  logic [127:0]        slot [NR+1];
  logic [127:0]        prev, next_key, rd_sel;
  logic [31:0]         w3, temp, n0, n1, n2, n3;
  logic [LANES-1:0][7:0] rot_w, sub_w;
  logic                zclr, accept;

`ifdef AES_KEY_ZEROIZE_EN
  assign zclr = zeroize;
`else
  assign zclr = 1'b0;
`endif

  assign accept     = start && (state != EXPAND);
  assign busy       = (state == EXPAND);
  assign keys_ready = (state == READY);

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    prev = slot[0];
    for (int i = 0; i < NR; i++)
      if (rc == 4'(i + 1)) prev = slot[i];
  end

  assign w3    = prev[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_sbox
    aes_sbox u_sbox (.din(rot_w[g]), .dout(sub_w[g]));
  end

  assign temp     = sub_w ^ {rcon(rc), 24'h0};
  assign n0       = prev[127:96] ^ temp;
  assign n1       = prev[95:64]  ^ n0;
  assign n2       = prev[63:32]  ^ n1;
  assign n3       = w3           ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NR; i++)
      if (rd_round == 4'(i)) rd_sel = slot[i];
  end

  always_comb begin
    state_nxt = state;
    if (zclr)                       state_nxt = IDLE;
    else if (accept)                state_nxt = EXPAND;
    else if (state == EXPAND && rc == 4'(NR)) state_nxt = READY;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || zclr) begin
      rc <= '0;
      for (int i = 0; i <= NR; i++) slot[i] <= '0;
    end else if (accept) begin
      rc      <= 4'd1;
      slot[0] <= key_in;
    end else if (state == EXPAND) begin
      for (int i = 1; i <= NR; i++)
        if (rc == 4'(i)) slot[i] <= next_key;
      if (rc != 4'(NR)) rc <= rc + 4'd1;
    end
  end

  // A start in READY blanks the read issued on that same edge.
  always_ff @(posedge clk) begin
    if (rst || zclr)
      rd_key <= '0;
    else if (state == READY && !start && rd_round <= 4'(NR))
      rd_key <= rd_sel;
    else
      rd_key <= '0;
  end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq: word-level FIPS-197 reference model,
// per-cycle comparison, and literal pins on published key vectors.

module tb_aes_key_schedule_seq;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key_in;
  logic [3:0]   rd_round;
  logic         busy, keys_ready;
  logic [127:0] rd_key;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize;
`endif

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.NR(10)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .start(start),
    .busy(busy), .keys_ready(keys_ready), .rd_round(rd_round),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .rd_key(rd_key)
  );

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_FIPS = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] y, b;
    y = 0;
    for (int c = 1; c < 256; c++)
      if (x != 0 && gm(x, 8'(c)) == 8'h01) y = 8'(c);
    b = 8'h63;
    for (int s = 0; s < 5; s++) b = b ^ ((y << s) | (y >> (8 - s)));
    return b;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcv;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcv, 24'h0};
        rcv = gm(rcv, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  logic [127:0] m_keys [11];
  logic         m_busy, m_ready;
  logic [127:0] m_rd;
  int           m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_ready <= 0; m_rd <= 0; m_left <= 0;
`ifdef AES_KEY_ZEROIZE_EN
    end else if (zeroize) begin
      m_busy <= 0; m_ready <= 0; m_rd <= 0; m_left <= 0;
`endif
    end else begin
      m_rd <= (m_ready && !start && rd_round <= 10) ? m_keys[rd_round] : 128'h0;
      if (start && !m_busy) begin
        for (int r = 0; r <= 10; r++) m_keys[r] <= round_key(key_in, r);
        m_busy <= 1; m_ready <= 0; m_left <= 10;
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin m_busy <= 0; m_ready <= 1; end
      end
    end
  end

  // ---------------- compare process ----------------
  int    errors = 0, checks = 0;
  bit    pinned = 0;
  bit    lit_en = 0;
  string lit_name;
  logic  lit_busy, lit_rdy;
  logic [127:0] lit_key;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!pinned) begin
      pinned <= 1;
      chk("model_fips_r1", round_key(K_FIPS, 1), R1_FIPS);
      chk("model_fips_r10", round_key(K_FIPS, 10), R10_FIPS);
      chk("model_c1_r10", round_key(K_C1, 10), R10_C1);
    end
    chk("busy", {127'h0, busy}, {127'h0, m_busy});
    chk("keys_ready", {127'h0, keys_ready}, {127'h0, m_ready});
    chk("rd_key", rd_key, m_rd);
    if (lit_en) begin
      chk({lit_name, "_busy"}, {127'h0, busy}, {127'h0, lit_busy});
      chk({lit_name, "_ready"}, {127'h0, keys_ready}, {127'h0, lit_rdy});
      chk({lit_name, "_key"}, rd_key, lit_key);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_lit(input string n, input logic b, input logic r, input logic [127:0] k);
    lit_name = n; lit_busy = b; lit_rdy = r; lit_key = k; lit_en = 1;
    @(negedge clk); #1;
    lit_en = 0;
  endtask

  task automatic wait_ready();
    repeat (10) tick();
  endtask

  initial begin
    rst = 1; start = 0; key_in = '0; rd_round = '0;
`ifdef AES_KEY_ZEROIZE_EN
    zeroize = 0;
`endif
    tick(); tick();
    expect_lit("reset", 0, 0, 0);
    rst = 0;

    // FIPS-197 vector with exact ready timing
    key_in = K_FIPS; start = 1; tick(); start = 0;
    expect_lit("start_busy", 1, 0, 0);
    repeat (9) tick();
    expect_lit("ready_minus1", 1, 0, 0);
    rd_round = 4'd1; tick();
    expect_lit("ready_edge_read", 0, 1, 0);
    tick(); expect_lit("fips_r1", 0, 1, R1_FIPS);
    rd_round = 4'd10; tick(); expect_lit("fips_r10", 0, 1, R10_FIPS);
    rd_round = 4'd0; tick(); expect_lit("fips_r0", 0, 1, K_FIPS);

    // reverse sweep plus out-of-range indices
    for (int r = 10; r >= 0; r--) begin rd_round = 4'(r); tick(); end
    rd_round = 4'd11; tick(); expect_lit("idx11", 0, 1, 0);
    rd_round = 4'd15; tick(); expect_lit("idx15", 0, 1, 0);

    // start while busy is ignored
    key_in = {$urandom, $urandom, $urandom, $urandom}; start = 1; tick(); start = 0;
    repeat (3) tick();
    key_in = {$urandom, $urandom, $urandom, $urandom}; start = 1; tick(); start = 0;
    repeat (6) tick();
    for (int r = 0; r <= 10; r++) begin rd_round = 4'(r); tick(); end

    // reset mid-run, then second published vector
    key_in = {$urandom, $urandom, $urandom, $urandom}; start = 1; tick(); start = 0;
    repeat (4) tick();
    rst = 1; tick(); rst = 0;
    expect_lit("rst_mid", 0, 0, 0);
    key_in = K_C1; start = 1; tick(); start = 0;
    wait_ready();
    rd_round = 4'd10; tick(); expect_lit("c1_r10", 0, 1, R10_C1);

    // restart from READY with reads every cycle
    key_in = {$urandom, $urandom, $urandom, $urandom}; rd_round = 4'd5; start = 1; tick(); start = 0;
    expect_lit("restart_read", 1, 0, 0);
    for (int i = 0; i < 14; i++) begin rd_round = 4'($urandom_range(0, 15)); tick(); end

`ifdef AES_KEY_ZEROIZE_EN
    rd_round = 4'd3; zeroize = 1; tick(); zeroize = 0;
    expect_lit("zeroize", 0, 0, 0);
    for (int r = 0; r <= 10; r++) begin rd_round = 4'(r); tick(); end
    key_in = K_FIPS; start = 1; tick(); start = 0;
    wait_ready(); tick();
    zeroize = 1; start = 1; tick(); zeroize = 0; start = 0;
    expect_lit("zeroize_vs_start", 0, 0, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      start    = ($urandom_range(0, 11) == 0);
      rd_round = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 299) == 0);
`ifdef AES_KEY_ZEROIZE_EN
      zeroize  = ($urandom_range(0, 149) == 0);
`endif
      tick();
    end
    rst = 0; start = 0;
`ifdef AES_KEY_ZEROIZE_EN
    zeroize = 0;
`endif
    tick();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
